cc2p_ks_ctrl: RTL
=================

CC2P_KS_CTRL -- requirements
Module: cc2p_ks_ctrl

Interface
REQ-001 SHALL have parameter BUF_WORDS, default 64, meaning capacity of the downstream 128-bit keystream buffer in words (multiple of 4, >= 8).
REQ-002 SHALL have parameter CW, default 7, meaning occupancy counter width (>= clog2(BUF_WORDS)+1).
REQ-003 SHALL have the following ports: i_clk in 1, the single clock; all logic on its rising edge.
REQ-004 i_rst in 1, synchronous, active-high reset.
REQ-005 i_cfg_load in 1, latch i_key, i_nonce and i_ctr_init (accepted only in IDLE).
REQ-006 i_key in 256, i_nonce in 96, i_ctr_init in 32: ChaCha20 key, nonce and initial block counter.
REQ-007 i_start in 1, begin keystream generation; i_stop in 1, end generation after the in-flight block.
REQ-008 o_core_start out 1, one-cycle launch pulse to the ChaCha20 core; o_core_key out 256, o_core_nonce out 96, o_core_ctr out 32: held stable from launch until i_core_done.
REQ-009 i_core_done in 1, core block complete; i_core_block in 512, keystream block, valid with i_core_done.
REQ-010 o_buf_en_w out 1, buffer write pulse; o_buf_data out 512, block to buffer, valid with o_buf_en_w.
REQ-011 o_buf_en_r out 1, buffer pop; i_buf_data in 128, buffer head word; i_buf_empty in 1, buffer empty flag.
REQ-012 o_ks_valid out 1, o_ks_word out 128, i_ks_ready in 1: consumer valid/ready keystream interface.
REQ-013 o_busy out 1, state != IDLE; o_ctr_ovf out 1, sticky block-counter exhaustion flag.

Function
REQ-014 SHALL implement FSM IDLE, LAUNCH, WAIT, WRITE, HOLD; the state register holds IDLE after reset.
REQ-015 IDLE->LAUNCH SHALL occur on i_start when o_ctr_ovf=0 and free words (BUF_WORDS - occ) >= 4; i_start with free < 4 SHALL be remembered (pending-run bit) and launched once space frees.
REQ-016 LAUNCH SHALL assert o_core_start for exactly one cycle, add 4 to occ (reservation), then go to WAIT.
REQ-017 WAIT->WRITE on i_core_done; WRITE SHALL pulse o_buf_en_w one cycle with o_buf_data = i_core_block captured at done.
REQ-018 HOLD SHALL last exactly 4 cycles (the buffer serialises one block over 4 cycles); no new o_buf_en_w during HOLD.
REQ-019 After HOLD: if stop pending or o_ctr_ovf, go to IDLE; else if free >= 4, go to LAUNCH; else wait in HOLD until free >= 4.
REQ-020 Block counter SHALL load i_ctr_init on i_cfg_load and increment by 1 at each LAUNCH; launch at counter 32'hFFFFFFFF SHALL set o_ctr_ovf, and the counter SHALL NOT wrap.
REQ-021 i_stop SHALL set a stop-pending bit, cleared on entry to IDLE; i_stop in IDLE SHALL have no effect.
REQ-022 o_ks_valid SHALL equal !i_buf_empty; o_ks_word SHALL equal i_buf_data (combinational); o_buf_en_r SHALL equal o_ks_valid & i_ks_ready.
REQ-023 occ SHALL decrement by 1 per o_buf_en_r; on a simultaneous reservation and pop, occ SHALL change by +3.
REQ-024 occ SHALL never exceed BUF_WORDS nor underflow; the consumer side SHALL keep operating in every state.
REQ-025 i_cfg_load outside IDLE SHALL be ignored.
REQ-026 i_core_done outside WAIT SHALL be ignored.

Reset
REQ-027 On i_rst: state IDLE, occ 0, counter 0, o_ctr_ovf 0, pending/stop bits 0, o_core_start 0, o_buf_en_w 0, o_busy 0.
REQ-028 Key, nonce and data registers SHALL reset to 0; reset mid-operation SHALL abandon any in-flight block, and a later i_core_done SHALL be ignored.

Structure
REQ-029 FSM state encoding, HOLD_CYCLES=4 and WORDS_PER_BLOCK=4 SHALL live in shared package cc2p_pkg.
REQ-030 The occupancy/credit counter SHALL be a sub-module cc2p_credit_cnt (reserve-4, release-1, free output).

Verification
REQ-031 Load ctr_init=5, i_start, core done after 10 cycles -> o_core_ctr=5, a single o_buf_en_w, next launch o_core_ctr=6 after 4-cycle HOLD.
REQ-032 BUF_WORDS=8, consumer never ready -> exactly 2 blocks launched, then stalled in HOLD; 4 pops -> third launch.
REQ-033 ctr_init=32'hFFFFFFFF -> one block produced, o_ctr_ovf=1, return to IDLE; i_start ignored until reset.
REQ-034 Consumer ready every cycle, continuous run -> 128-bit words delivered in order w0..w3 per block; occ never exceeds 8 with one block in flight.
REQ-035 i_stop during WAIT -> block still written, then IDLE, o_busy=0.
REQ-036 i_rst asserted in WAIT then i_core_done -> no o_buf_en_w, and all outputs at reset values.

Source files
------------

// File: rtl/cc2p_pkg.sv
// Shared definitions for the ChaCha20 keystream controller: FSM encoding,
// block geometry and the latched key/nonce configuration record.
package cc2p_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  localparam int HOLD_CYCLES     = 4;
  localparam int WORDS_PER_BLOCK = 4;

  typedef struct packed {
    logic [255:0] key;
    logic [95:0]  nonce;
  } cc2p_cfg_t;

endpackage

// File: rtl/cc2p_credit_cnt.sv
// Buffer occupancy tracker: a launch reserves a whole block of words up front,
// each consumer pop releases one word.
module cc2p_credit_cnt
  import cc2p_pkg::*;
#(
  parameter int BUF_WORDS = 64,
  parameter int CW        = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_reserve,
  input  logic          i_release,
  output logic [CW-1:0] o_free
);

  localparam logic [CW-1:0] CAP = CW'(BUF_WORDS);
  localparam logic [CW-1:0] BLK = CW'(WORDS_PER_BLOCK);

  logic [CW-1:0] occ_q;
  logic [CW-1:0] occ_d;

  always_comb begin
    // NOTE: occ_d gets a default before any branch so no path can infer a latch.
    occ_d = occ_q;
    if (i_reserve) occ_d = (occ_q > CAP - BLK) ? CAP : occ_q + BLK;
    if (i_release && (occ_d != '0)) occ_d = occ_d - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with <= only, so every reader sees the pre-edge value.
    if (i_rst) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign o_free = CAP - occ_q;

endmodule

// File: rtl/cc2p_ks_ctrl.sv
// Keystream controller: launches ChaCha20 blocks while the downstream buffer
// has room for a whole block, forwards results and exposes a valid/ready tap.
module cc2p_ks_ctrl
  import cc2p_pkg::*;
#(
  parameter int BUF_WORDS = 64,
  parameter int CW        = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cfg_load,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_nonce,
  input  logic [31:0]  i_ctr_init,
  input  logic         i_start,
  input  logic         i_stop,
  output logic         o_core_start,
  output logic [255:0] o_core_key,
  output logic [95:0]  o_core_nonce,
  output logic [31:0]  o_core_ctr,
  input  logic         i_core_done,
  input  logic [511:0] i_core_block,
  output logic         o_buf_en_w,
  output logic [511:0] o_buf_data,
  output logic         o_buf_en_r,
  input  logic [127:0] i_buf_data,
  input  logic         i_buf_empty,
  output logic         o_ks_valid,
  output logic [127:0] o_ks_word,
  input  logic         i_ks_ready,
  output logic         o_busy,
  output logic         o_ctr_ovf
);

  localparam int              HCW       = $clog2(HOLD_CYCLES);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  logic [2:0]     state_q, state_d;
  cc2p_cfg_t      cfg_q;
  logic [31:0]    ctr_q;
  logic [31:0]    core_ctr_q;
  logic [511:0]   blk_q;
  logic [HCW-1:0] hold_cnt_q;
  logic           ovf_q, pend_q, stop_q;
  logic [CW-1:0]  free;
  logic           room;

  assign room = (free >= CW'(WORDS_PER_BLOCK));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if ((i_start || pend_q) && !ovf_q && room) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (i_core_done) state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_HOLD;
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (stop_q || i_stop || ovf_q) state_d = ST_IDLE;
          else if (room)                 state_d = ST_LAUNCH;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: key/nonce/block registers are reset too, so an abandoned run leaves no stale data on the ports.
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      ctr_q      <= '0;
      core_ctr_q <= '0;
      blk_q      <= '0;
      hold_cnt_q <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == ST_IDLE) && i_cfg_load) begin
        cfg_q <= '{key: i_key, nonce: i_nonce};
        ctr_q <= i_ctr_init;
      end

      // The counter never wraps: the last legal block raises the sticky flag instead.
      if (state_q == ST_LAUNCH) begin
        if (ctr_q == '1) ovf_q <= 1'b1;
        else             ctr_q <= ctr_q + 32'd1;
      end
      if (state_d == ST_LAUNCH) core_ctr_q <= ctr_q;

      if (state_q == ST_IDLE) begin
        if (state_d == ST_LAUNCH)     pend_q <= 1'b0;
        else if (i_start && !ovf_q)   pend_q <= 1'b1;
      end

      if (state_d == ST_IDLE)                    stop_q <= 1'b0;
      else if (i_stop && (state_q != ST_IDLE))   stop_q <= 1'b1;

      if ((state_q == ST_WAIT) && i_core_done) blk_q <= i_core_block;

      if (state_q != ST_HOLD)              hold_cnt_q <= '0;
      else if (hold_cnt_q != HOLD_LAST)    hold_cnt_q <= hold_cnt_q + HCW'(1);
    end
  end

  cc2p_credit_cnt #(
    .BUF_WORDS (BUF_WORDS),
    .CW        (CW)
  ) u_credit (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_reserve (state_q == ST_LAUNCH),
    .i_release (o_buf_en_r),
    .o_free    (free)
  );

  assign o_core_start = (state_q == ST_LAUNCH);
  assign o_core_key   = cfg_q.key;
  assign o_core_nonce = cfg_q.nonce;
  assign o_core_ctr   = core_ctr_q;
  assign o_buf_en_w   = (state_q == ST_WRITE);
  assign o_buf_data   = blk_q;
  assign o_ks_valid   = !i_buf_empty;
  assign o_ks_word    = i_buf_data;
  assign o_buf_en_r   = o_ks_valid & i_ks_ready;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_ctr_ovf    = ovf_q;

endmodule
